// File: rtl/jts16_busarb.sv
// jts16_busarb: lets an external MCU borrow the 68000 bus via BR/BG/BGACK, bursting up to 4 accesses.
// Optional grant timeout is compiled in by defining JTS16_BUSARB_TIMEOUT_EN.
module jts16_busarb (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_cen,
    output logic        BRn,
    input  logic        BGn,
    output logic        BGACKn,
    input  logic        ASn,
    input  logic        DTACKn,
    input  logic        mcu_req,
    input  logic        mcu_rnw,
    input  logic [23:1] mcu_addr,
    input  logic [15:0] mcu_dout,
    input  logic [1:0]  mcu_dsn,
    output logic [15:0] mcu_din,
    output logic        mcu_ack,
    output logic        ext_asn,
    output logic        ext_rnw,
    output logic [23:1] ext_addr,
    output logic [15:0] ext_dout,
    output logic [1:0]  ext_dsn,
    input  logic [15:0] bus_din,
    output logic        mcu_err
);

    typedef enum logic [2:0] {IDLE, REQ, SYNC, OWN, CYCLE, REL} state_t;

    localparam logic [2:0] BURST_MAX = 3'd4;

    state_t     state_q;
    logic [2:0] burst_q;
    logic [1:0] dsn_q;
    logic       go_own;
    logic       tmo_fire;

    // The CPU cycle in flight ends on the tick where AS and DTACK are both idle.
    assign go_own = mcu_req &&
                    ((state_q == SYNC && ASn && DTACKn) ||
                     (state_q == REL  && burst_q != BURST_MAX));

`ifdef JTS16_BUSARB_TIMEOUT_EN
    logic [7:0] tmo_q;

    assign tmo_fire = mcu_req && (tmo_q == 8'd254) &&
                      (state_q == REQ || (state_q == SYNC && !(ASn && DTACKn)));
`else
    assign tmo_fire = 1'b0;
    assign mcu_err  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            burst_q  <= '0;
            dsn_q    <= 2'b11;
            BRn      <= 1'b1;
            BGACKn   <= 1'b1;
            ext_asn  <= 1'b1;
            ext_dsn  <= 2'b11;
            ext_rnw  <= 1'b1;
            ext_addr <= '0;
            ext_dout <= '0;
            mcu_din  <= 16'hFFFF;
            mcu_ack  <= 1'b0;
`ifdef JTS16_BUSARB_TIMEOUT_EN
            tmo_q    <= '0;
            mcu_err  <= 1'b0;
`endif
        end else begin
            // NOTE: defaulting mcu_ack low every clk (not every cen) keeps the ack exactly one clk wide.
            mcu_ack <= 1'b0;
            if (cpu_cen) begin
                if (go_own) begin
                    ext_rnw  <= mcu_rnw;
                    ext_addr <= mcu_addr;
                    ext_dout <= mcu_dout;
                    dsn_q    <= mcu_dsn;
                end
`ifdef JTS16_BUSARB_TIMEOUT_EN
                tmo_q <= (state_q == REQ || state_q == SYNC) ? tmo_q + 8'd1 : 8'd0;
                if (tmo_fire) mcu_err <= 1'b1;
`endif
                unique case (state_q)
                    IDLE: begin
                        if (mcu_req) begin
                            state_q <= REQ;
                            BRn     <= 1'b0;
                        end
                    end
                    REQ: begin
                        if (!mcu_req || tmo_fire) begin
                            state_q <= IDLE;
                            BRn     <= 1'b1;
                        end else if (!BGn) begin
                            state_q <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (!mcu_req || tmo_fire) begin
                            state_q <= IDLE;
                            BRn     <= 1'b1;
                        end else if (go_own) begin
                            state_q <= OWN;
                            BGACKn  <= 1'b0;
                            BRn     <= 1'b1;
                            burst_q <= '0;
                        end
                    end
                    OWN: begin
                        state_q <= CYCLE;
                        ext_asn <= 1'b0;
                        ext_dsn <= dsn_q;
                    end
                    CYCLE: begin
                        if (!DTACKn) begin
                            if (ext_rnw) mcu_din <= bus_din;
                            mcu_ack <= 1'b1;
                            ext_asn <= 1'b1;
                            ext_dsn <= 2'b11;
                            burst_q <= burst_q + 3'd1;
                            state_q <= REL;
                        end
                    end
                    REL: begin
                        if (go_own) begin
                            state_q <= OWN;
                        end else begin
                            state_q <= IDLE;
                            BGACKn  <= 1'b1;
                            burst_q <= '0;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_jts16_busarb.sv
// tb_jts16_busarb: directed table-driven and sequence checks for the MCU bus arbiter.
// One tick() = one cen clock followed by one non-cen clock; outputs sampled 1 ns after the edge.
module tb_jts16_busarb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_cen = 1'b0;
    logic        BRn, BGACKn;
    logic        BGn = 1'b1, ASn = 1'b1, DTACKn = 1'b1;
    logic        mcu_req = 1'b0, mcu_rnw = 1'b1;
    logic [23:1] mcu_addr = '0;
    logic [15:0] mcu_dout = '0;
    logic [1:0]  mcu_dsn = 2'b11;
    logic [15:0] mcu_din;
    logic        mcu_ack;
    logic        ext_asn, ext_rnw;
    logic [23:1] ext_addr;
    logic [15:0] ext_dout;
    logic [1:0]  ext_dsn;
    logic [15:0] bus_din = '0;
    logic        mcu_err;

    int n_tests = 0;
    int n_fail  = 0;

    jts16_busarb dut (
        .clk(clk), .rst_n(rst_n), .cpu_cen(cpu_cen),
        .BRn(BRn), .BGn(BGn), .BGACKn(BGACKn),
        .ASn(ASn), .DTACKn(DTACKn),
        .mcu_req(mcu_req), .mcu_rnw(mcu_rnw), .mcu_addr(mcu_addr),
        .mcu_dout(mcu_dout), .mcu_dsn(mcu_dsn),
        .mcu_din(mcu_din), .mcu_ack(mcu_ack),
        .ext_asn(ext_asn), .ext_rnw(ext_rnw), .ext_addr(ext_addr),
        .ext_dout(ext_dout), .ext_dsn(ext_dsn),
        .bus_din(bus_din), .mcu_err(mcu_err)
    );

    always #5 clk = ~clk;

    // Bus monitors sampled on the falling edge, away from the active edge.
    int          ack_cnt = 0, ack_wide = 0, asn_low_cnt = 0, dsn_err = 0, stable_err = 0;
    logic        ack_prev = 1'b0, asn_prev = 1'b1;
    logic [41:0] held = '0;

    always @(negedge clk) begin
        if (mcu_ack === 1'b1) ack_cnt++;
        if (mcu_ack === 1'b1 && ack_prev) ack_wide++;
        ack_prev = (mcu_ack === 1'b1);
        if (ext_asn === 1'b0) asn_low_cnt++;
        if (ext_asn === 1'b1 && ext_dsn !== 2'b11) dsn_err++;
        if (ext_asn === 1'b0 && !asn_prev && {ext_addr, ext_dout, ext_dsn, ext_rnw} !== held) stable_err++;
        asn_prev = (ext_asn !== 1'b0);
        held     = {ext_addr, ext_dout, ext_dsn, ext_rnw};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        cpu_cen = 1'b1;
        @(posedge clk); #1;
        cpu_cen = 1'b0;
        @(posedge clk); #1;
    endtask

    typedef struct {
        logic        req;
        logic        bgn;
        logic        asn;
        logic        dtackn;
        logic [15:0] din;
        logic        brn;
        logic        bgackn;
        logic        e_asn;
        logic [1:0]  dsn;
        logic [15:0] mdin;
    } vec_t;

    vec_t vecs [9];

    int a0, lo0, rel, brn_falls, ack_at_rel, asn_hi, err_tick, brn_hi;
    logic prev_bg, prev_br, brn_at_err, wr_seen;

    initial begin
        // Single read: {req,BGn,ASn,DTACKn,bus_din} -> {BRn,BGACKn,ext_asn,ext_dsn,mcu_din}
        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 2'b11, 16'hFFFF}; // IDLE
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b11, 16'hFFFF}; // REQ
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b11, 16'hFFFF}; // REQ wait
        vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b11, 16'hFFFF}; // SYNC
        vecs[4] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 2'b11, 16'hFFFF}; // OWN
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 2'b00, 16'hFFFF}; // CYCLE
        vecs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b0, 1'b0, 2'b00, 16'hFFFF}; // CYCLE wait
        vecs[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 16'hA55A, 1'b1, 1'b0, 1'b1, 2'b11, 16'hA55A}; // REL
        vecs[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 2'b11, 16'hA55A}; // IDLE

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_brn", BRn, 1);
        check("rst_bgackn", BGACKn, 1);
        check("rst_ext_asn", ext_asn, 1);
        check("rst_ext_dsn", ext_dsn, 2'b11);
        check("rst_ext_rnw", ext_rnw, 1);
        check("rst_ext_addr", ext_addr, 0);
        check("rst_ext_dout", ext_dout, 0);
        check("rst_mcu_din", mcu_din, 16'hFFFF);
        check("rst_mcu_ack", mcu_ack, 0);
        check("rst_mcu_err", mcu_err, 0);
        rst_n = 1'b1;
        tick();

        // Single read through the vector table
        mcu_rnw = 1'b1; mcu_addr = 23'h200000; mcu_dsn = 2'b00; mcu_dout = 16'h0000;
        a0 = ack_cnt;
        for (int i = 0; i < 9; i++) begin
            mcu_req = vecs[i].req; BGn = vecs[i].bgn; ASn = vecs[i].asn;
            DTACKn = vecs[i].dtackn; bus_din = vecs[i].din;
            tick();
            check($sformatf("rd%0d_brn", i), BRn, vecs[i].brn);
            check($sformatf("rd%0d_bgackn", i), BGACKn, vecs[i].bgackn);
            check($sformatf("rd%0d_ext_asn", i), ext_asn, vecs[i].e_asn);
            check($sformatf("rd%0d_ext_dsn", i), ext_dsn, vecs[i].dsn);
            check($sformatf("rd%0d_mcu_din", i), mcu_din, vecs[i].mdin);
        end
        check("rd_ack_count", ack_cnt - a0, 1);
        check("rd_ext_addr", ext_addr, 23'h200000);
        check("rd_ext_rnw", ext_rnw, 1);

        // CPU cycle in flight when the grant arrives
        mcu_req = 1'b1; BGn = 1'b1; ASn = 1'b1; DTACKn = 1'b1;
        tick();
        check("inflight_brn", BRn, 0);
        BGn = 1'b0; ASn = 1'b0;
        tick();
        asn_hi = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ext_asn && BGACKn) asn_hi++;
        end
        check("inflight_wait_ticks", asn_hi, 5);
        ASn = 1'b1; DTACKn = 1'b0;
        tick();
        check("inflight_dtack_wait_bgackn", BGACKn, 1);
        DTACKn = 1'b1;
        tick();
        check("inflight_own_bgackn", BGACKn, 0);
        check("inflight_own_asn", ext_asn, 1);
        tick();
        check("inflight_cycle_asn", ext_asn, 0);
        BGn = 1'b1; DTACKn = 1'b0; bus_din = 16'h0F0F; mcu_req = 1'b0;
        tick();
        check("inflight_mcu_din", mcu_din, 16'h0F0F);
        DTACKn = 1'b1;
        tick();
        check("inflight_end_bgackn", BGACKn, 1);

        // Burst limit: 6 back-to-back writes need two grants
        mcu_req = 1'b1; mcu_rnw = 1'b0; mcu_addr = 23'h000100; mcu_dout = 16'hBEEF; mcu_dsn = 2'b00;
        a0 = ack_cnt; rel = 0; brn_falls = 0; ack_at_rel = -1;
        prev_bg = BGACKn; prev_br = BRn;
        for (int i = 0; i < 200 && (ack_cnt - a0) < 6; i++) begin
            BGn = BRn; DTACKn = ext_asn; ASn = 1'b1;
            tick();
            if (prev_br && !BRn) brn_falls++;
            if (!prev_bg && BGACKn) begin
                rel++;
                if (ack_at_rel < 0) ack_at_rel = ack_cnt - a0;
            end
            prev_bg = BGACKn; prev_br = BRn;
        end
        check("burst_acks", ack_cnt - a0, 6);
        check("burst_first_release_ack", ack_at_rel, 4);
        check("burst_releases_mid", rel, 1);
        check("burst_brn_handshakes", brn_falls, 2);
        mcu_req = 1'b0; BGn = 1'b1; DTACKn = 1'b1;
        tick();
        check("burst_end_bgackn", BGACKn, 1);
        check("burst_end_acks", ack_cnt - a0, 6);

        // Abort in REQ (simultaneous with grant) and in SYNC
        lo0 = asn_low_cnt; a0 = ack_cnt;
        mcu_req = 1'b1; BGn = 1'b1;
        tick();
        check("abort_req_brn_low", BRn, 0);
        mcu_req = 1'b0; BGn = 1'b0;
        tick();
        check("abort_req_brn", BRn, 1);
        tick();
        tick();
        check("abort_req_idle_bgackn", BGACKn, 1);
        check("abort_req_idle_brn", BRn, 1);
        BGn = 1'b1; mcu_req = 1'b1;
        tick();
        BGn = 1'b0; ASn = 1'b0;
        tick();
        check("abort_sync_brn_low", BRn, 0);
        mcu_req = 1'b0;
        tick();
        check("abort_sync_brn", BRn, 1);
        ASn = 1'b1;
        tick();
        tick();
        check("abort_sync_bgackn", BGACKn, 1);
        BGn = 1'b1;
        check("abort_no_ack", ack_cnt - a0, 0);
        check("abort_no_asn", asn_low_cnt - lo0, 0);

        // Grant never arrives
        mcu_req = 1'b1; BGn = 1'b1; ASn = 1'b1; DTACKn = 1'b1;
        a0 = ack_cnt;
        tick();
        err_tick = -1; brn_at_err = 1'b0; brn_hi = 0;
        for (int i = 1; i <= 300; i++) begin
            tick();
            if (BRn) brn_hi++;
            if (mcu_err && err_tick < 0) begin
                err_tick   = i;
                brn_at_err = BRn;
            end
        end
`ifdef JTS16_BUSARB_TIMEOUT_EN
        check("tmo_err_tick", err_tick, 255);
        check("tmo_brn_at_err", brn_at_err, 1);
        check("tmo_err_sticky", mcu_err, 1);
`else
        check("no_tmo_brn_held", brn_hi, 0);
        check("no_tmo_err", mcu_err, 0);
`endif
        check("tmo_no_ack", ack_cnt - a0, 0);
        mcu_req = 1'b0;
        tick();
        check("tmo_end_brn", BRn, 1);

        // Reset asserted during CYCLE, then a fresh write
        mcu_req = 1'b1; mcu_rnw = 1'b0; mcu_addr = 23'h123456; mcu_dout = 16'h5A5A; mcu_dsn = 2'b01;
        for (int i = 0; i < 20 && ext_asn; i++) begin
            BGn = BRn; DTACKn = 1'b1;
            tick();
        end
        check("rstcyc_reached_cycle", ext_asn, 0);
        a0 = ack_cnt;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstcyc_bgackn", BGACKn, 1);
        check("rstcyc_ext_asn", ext_asn, 1);
        check("rstcyc_ext_dsn", ext_dsn, 2'b11);
        check("rstcyc_brn", BRn, 1);
        check("rstcyc_mcu_err", mcu_err, 0);
        check("rstcyc_mcu_din", mcu_din, 16'hFFFF);
        mcu_req = 1'b0; BGn = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("rstcyc_idle_brn", BRn, 1);
        check("rstcyc_idle_bgackn", BGACKn, 1);
        check("rstcyc_no_ack", ack_cnt - a0, 0);

        mcu_req = 1'b1; mcu_rnw = 1'b0; mcu_addr = 23'h0ABCDE; mcu_dout = 16'hC3C3; mcu_dsn = 2'b10;
        bus_din = 16'h7777; a0 = ack_cnt; wr_seen = 1'b0;
        for (int i = 0; i < 30 && ack_cnt == a0; i++) begin
            BGn = BRn; DTACKn = ext_asn;
            tick();
            if (!ext_asn && !wr_seen) begin
                wr_seen = 1'b1;
                check("post_wr_addr", ext_addr, 23'h0ABCDE);
                check("post_wr_dout", ext_dout, 16'hC3C3);
                check("post_wr_rnw", ext_rnw, 0);
                check("post_wr_dsn", ext_dsn, 2'b10);
            end
        end
        check("post_wr_cycle_seen", wr_seen, 1);
        check("post_wr_acks", ack_cnt - a0, 1);
        check("post_wr_mcu_din_kept", mcu_din, 16'hFFFF);
        mcu_req = 1'b0; BGn = 1'b1; DTACKn = 1'b1;
        tick();
        check("post_wr_bgackn", BGACKn, 1);

        // Whole-run bus properties
        check("ack_one_clk_wide", ack_wide, 0);
        check("ext_stable_in_cycle", stable_err, 0);
        check("ext_dsn_idle_outside_cycle", dsn_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/jts16_busarb.md
JTS16_BUSARB -- requirements
Module: jts16_busarb

Interface
REQ-001 SHALL have port clk input 1: system clock; all logic on rising edge.
REQ-002 SHALL have port rst_n input 1: asynchronous, active-low reset.
REQ-003 SHALL have port cpu_cen input 1: 68000 clock enable; every FSM transition and counter step is qualified by it.
REQ-004 SHALL have ports BRn output 1, BGn input 1, BGACKn output 1: 68000 bus request, grant and grant-acknowledge.
REQ-005 SHALL have ports ASn input 1, DTACKn input 1: CPU address strobe and shared-bus DTACK from the bus DTACK generator.
REQ-006 SHALL have ports mcu_req input 1, mcu_rnw input 1, mcu_addr input 23 ([23:1]), mcu_dout input 16, mcu_dsn input 2 ({UDSn,LDSn}): external-master (MCU) access request.
REQ-007 SHALL have ports mcu_din output 16 and mcu_ack output 1: read data and one-cycle completion pulse.
REQ-008 SHALL have ports ext_asn output 1, ext_rnw output 1, ext_addr output 23, ext_dout output 16, ext_dsn output 2: bus drive while owned; bus_din input 16: shared data bus.
REQ-009 SHALL have port mcu_err output 1: sticky grant-timeout flag (with timeout feature only; tied 0 otherwise).

Function
REQ-010 SHALL implement states IDLE, REQ, SYNC, OWN, CYCLE, REL.
REQ-011 IDLE: BRn=1, BGACKn=1; on mcu_req=1, go to REQ and drive BRn=0.
REQ-012 REQ: hold BRn=0; on BGn=0, go to SYNC.
REQ-013 SYNC: advance to OWN only when ASn=1 and DTACKn=1 on the same cen tick; this tick marks the end of any CPU cycle in flight.
REQ-014 OWN: drive BGACKn=0 and BRn=1 on entry; latch mcu_addr/rnw/dout/dsn into ext_* registers; go to CYCLE.
REQ-015 CYCLE: ext_asn=0 and ext_dsn=latched value; on DTACKn=0, capture bus_din into mcu_din when ext_rnw=1; pulse mcu_ack for exactly one clk; go to REL.
REQ-016 REL: ext_asn=1, ext_dsn=2'b11; if mcu_req is still 1, return to OWN (back-to-back access, BGACKn stays 0); otherwise BGACKn=1 and go to IDLE.
REQ-017 Burst limit: at most 4 consecutive accesses per grant; the 4th REL SHALL release the bus (BGACKn=1) and pass through IDLE for at least one cen tick, even with mcu_req=1.
REQ-018 Outside CYCLE, ext_asn=1 and ext_dsn=2'b11; ext_* SHALL be stable throughout CYCLE.
REQ-019 mcu_req falling in REQ or SYNC SHALL abort to IDLE with BRn=1 and no mcu_ack.
REQ-020 Simultaneous BGn=0 and mcu_req=0 in REQ: abort wins.
REQ-021 Latency: mcu_req rise to BRn=0 is one cen tick; BGn=0 with an idle bus to ext_asn=0 is three cen ticks (SYNC, OWN, CYCLE).

Reset
REQ-022 With rst_n=0, outputs SHALL be: BRn=1, BGACKn=1, ext_asn=1, ext_dsn=2'b11, ext_rnw=1, ext_addr=0, ext_dout=0, mcu_din=16'hFFFF, mcu_ack=0, mcu_err=0, state IDLE, burst count 0.
REQ-023 Reset asserted mid-cycle SHALL release the bus immediately (asynchronously) and drop any pending access without mcu_ack.

Configuration
REQ-024 The macro JTS16_BUSARB_TIMEOUT_EN SHALL control the grant timeout. When defined: an 8-bit counter runs in REQ and SYNC; after 255 cen ticks without reaching OWN, the block SHALL set mcu_err=1, return to IDLE with BRn=1, and emit no mcu_ack. mcu_err SHALL clear only on reset. When undefined: no counter, REQ and SYNC wait indefinitely, mcu_err=0.

Verification
REQ-025 Single read: mcu_req=1, rnw=1, addr=23'h200000; BGn=0 two ticks after BRn=0; DTACKn=0 with bus_din=16'hA55A -> mcu_din=16'hA55A, one mcu_ack pulse, BGACKn returns to 1.
REQ-026 CPU cycle in flight: ASn=0 when BGn=0, held 5 ticks -> ext_asn stays 1 until one tick after ASn=1 and DTACKn=1.
REQ-027 Burst: mcu_req held high for 6 accesses -> 4 mcu_ack pulses, BGACKn=1 for at least one tick, then 2 more pulses under a fresh BRn/BGn handshake.
REQ-028 Abort: mcu_req drops while in REQ -> BRn=1 next tick, no mcu_ack, ext_asn never 0.
REQ-029 Timeout (JTS16_BUSARB_TIMEOUT_EN defined): BGn held 1 for 300 ticks -> mcu_err=1 at tick 255, BRn=1; without the macro, BRn stays 0.
REQ-030 Reset during CYCLE: rst_n=0 -> BGACKn=1, ext_asn=1 at once; after release the block is IDLE and a new request completes normally.
